// File: rtl/fft_pair_feeder.sv
// Input reorder stage for a radix-2 FFT: buffers the first half-frame, then
// pairs each second-half sample with its partner x[k] on a registered output.
module fft_pair_feeder #(
  parameter int N  = 16,
  parameter int DW = 16,
  localparam int KW = $clog2(N) - 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_re,
  input  logic signed [DW-1:0] s_im,
  output logic                 p_valid,
  input  logic                 p_ready,
  output logic signed [DW-1:0] p_ar,
  output logic signed [DW-1:0] p_ai,
  output logic signed [DW-1:0] p_br,
  output logic signed [DW-1:0] p_bi,
  output logic [KW-1:0]        p_idx,
  output logic                 p_last
);

  localparam int H = N / 2;

  typedef enum logic {FILL, PAIR} state_t;

  state_t          state;
  logic [KW-1:0]   cnt;
  logic [2*DW-1:0] mem [H];
  logic [2*DW-1:0] rd;
  logic            accept;
  logic            cnt_last;

  // FILL never touches the output register, so it may run while a pair waits
  assign s_ready  = (state == FILL) ? 1'b1 : (!p_valid || p_ready);
  assign accept   = s_valid && s_ready;
  assign cnt_last = (cnt == KW'(H - 1));
  assign rd       = mem[cnt];

  always_ff @(posedge clk) begin
    if (state == FILL && accept)
      mem[cnt] <= {s_re, s_im};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= FILL;
      cnt     <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_idx   <= '0;
      p_ar    <= '0;
      p_ai    <= '0;
      p_br    <= '0;
      p_bi    <= '0;
    end else begin
      if (accept) begin
        cnt <= cnt_last ? '0 : cnt + 1'b1;
        if (cnt_last)
          state <= (state == FILL) ? PAIR : FILL;
      end

      // a load in the same cycle as an unload keeps p_valid high: no bubble
      if (state == PAIR && accept) begin
        p_ar    <= rd[2*DW-1:DW];
        p_ai    <= rd[DW-1:0];
        p_br    <= s_re;
        p_bi    <= s_im;
        p_idx   <= cnt;
        p_last  <= cnt_last;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Self-checking bench for fft_pair_feeder (N=8): directed scenarios plus a
// randomized run, checked against a frame-level model of the pairing rule.
module tb_fft_pair_feeder;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int H  = N / 2;
  localparam int KW = $clog2(N) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_re, s_im;
  logic          p_valid;
  logic          p_ready;
  logic [DW-1:0] p_ar, p_ai, p_br, p_bi;
  logic [KW-1:0] p_idx;
  logic          p_last;

  int checks = 0;
  int errors = 0;

  // model: samples of the current frame, position in frame, held output pair
  logic [DW-1:0] frame_re [N];
  logic [DW-1:0] frame_im [N];
  int            pos;
  logic          exp_valid;
  logic [DW-1:0] exp_ar, exp_ai, exp_br, exp_bi;
  logic [KW-1:0] exp_idx;
  logic          exp_last;
  int            pairs_out;
  int            sready_low;

  always #5 clk = ~clk;

  fft_pair_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .p_valid(p_valid), .p_ready(p_ready),
    .p_ar(p_ar), .p_ai(p_ai), .p_br(p_br), .p_bi(p_bi),
    .p_idx(p_idx), .p_last(p_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    chk({tag, " p_valid"}, 64'(p_valid), 64'(exp_valid));
    chk({tag, " p_ar"},    64'(p_ar),    64'(exp_ar));
    chk({tag, " p_ai"},    64'(p_ai),    64'(exp_ai));
    chk({tag, " p_br"},    64'(p_br),    64'(exp_br));
    chk({tag, " p_bi"},    64'(p_bi),    64'(exp_bi));
    chk({tag, " p_idx"},   64'(p_idx),   64'(exp_idx));
    chk({tag, " p_last"},  64'(p_last),  64'(exp_last));
  endtask

  // one clock: drive after negedge, sample handshakes before posedge, check after
  task automatic apply_stimulus(input logic sv, input logic [DW-1:0] re,
                                input logic [DW-1:0] im, input logic pr,
                                output logic acc);
    logic cons, exp_sr;
    @(negedge clk);
    s_valid = sv; s_re = re; s_im = im; p_ready = pr;
    #3;
    exp_sr = (pos < H) ? 1'b1 : (!p_valid || p_ready);
    chk("s_ready", 64'(s_ready), 64'(exp_sr));
    if (!s_ready) sready_low++;
    acc  = sv && s_ready;
    cons = p_valid && p_ready;
    @(posedge clk);
    #1;
    if (cons) pairs_out++;
    if (acc) begin
      frame_re[pos] = re;
      frame_im[pos] = im;
      if (pos >= H) begin
        exp_valid = 1'b1;
        exp_ar    = frame_re[pos-H];
        exp_ai    = frame_im[pos-H];
        exp_br    = re;
        exp_bi    = im;
        exp_idx   = KW'(pos - H);
        exp_last  = (pos == N - 1);
      end else if (cons) begin
        exp_valid = 1'b0;
      end
      pos = (pos + 1) % N;
    end else if (cons) begin
      exp_valid = 1'b0;
    end
    check_output("cycle");
  endtask

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
    logic acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      apply_stimulus(1'b1, re, im, 1'b1, acc);
      tries++;
    end
    chk("send accepted", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 1'b0; p_ready = 1'b0;
    rstn = 1'b0;
    #1;
    pos = 0;
    exp_valid = 1'b0; exp_ar = '0; exp_ai = '0; exp_br = '0; exp_bi = '0;
    exp_idx = '0; exp_last = 1'b0;
    check_output("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic acc;
    int base, accepted, cyc;
    rstn = 1'b0; s_valid = 1'b0; p_ready = 1'b0; s_re = '0; s_im = '0;
    pos = 0; pairs_out = 0; sready_low = 0;
    do_reset();

    // natural-order frame, continuous flow
    base = pairs_out;
    for (int n = 0; n < N; n++) begin
      send(DW'(n), DW'(100 + n));
      if (n == H) begin
        chk("t1 first br", 64'(p_br), 64'd4);
        chk("t1 first bi", 64'(p_bi), 64'd104);
      end
    end
    chk("t1 last flag", 64'(p_last), 64'd1);
    idle(2);
    chk("t1 pair count", 64'(pairs_out - base), 64'(H));

    // backpressure after pair 1
    base = pairs_out;
    for (int n = 0; n < H + 2; n++) send(DW'(n), DW'(100 + n));
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, DW'(H + 2), DW'(102 + H), 1'b0, acc);
    for (int n = H + 2; n < N; n++) send(DW'(n), DW'(100 + n));
    idle(2);
    chk("t2 pair count", 64'(pairs_out - base), 64'(H));

    // two back-to-back frames
    base = pairs_out;
    sready_low = 0;
    for (int n = 0; n < N; n++) send(DW'(n), DW'(n + 7));
    for (int n = 0; n < N; n++) send(DW'(50 + n), DW'(150 + n));
    chk("t3 s_ready low count", 64'(sready_low), 64'd0);
    idle(2);
    chk("t3 pair count", 64'(pairs_out - base), 64'(2 * H));

    // reset after two pairs, then a clean frame
    for (int n = 0; n < H + 2; n++) send(DW'(n), DW'(200 + n));
    do_reset();
    for (int n = 0; n < N; n++) begin
      send(DW'(30 + n), DW'(130 + n));
      if (n == H) chk("t4 idx after reset", 64'(p_idx), 64'd0);
    end
    idle(2);

    // full-scale values pass bit-exact
    send(16'h8000, 16'h7FFF);
    for (int n = 1; n < H; n++) send(DW'(n), DW'(n));
    send(16'h7FFF, 16'h8000);
    chk("t5 ar", 64'(p_ar), 64'h8000);
    chk("t5 ai", 64'(p_ai), 64'h7FFF);
    chk("t5 br", 64'(p_br), 64'h7FFF);
    chk("t5 bi", 64'(p_bi), 64'h8000);
    for (int n = H + 1; n < N; n++) send(DW'(n), DW'(n));
    idle(2);

    // random gaps on both sides, 20 frames
    base = pairs_out;
    accepted = 0;
    cyc = 0;
    while (accepted < 20 * N && cyc < 4000) begin
      apply_stimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                     1'($urandom_range(0, 1)), acc);
      if (acc) accepted++;
      cyc++;
    end
    chk("t6 samples accepted", 64'(accepted), 64'(20 * N));
    idle(3);
    chk("t6 pair count", 64'(pairs_out - base), 64'(20 * H));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
